// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: fetch FSM states,
// datapath widths, the default reset fetch address and a PC alignment helper.
package ifetch_queue_pkg;

   localparam int INSN_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   // Fetch addresses are always word aligned; the low two bits are forced to zero.
   function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] pc);
      return pc & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO of {pc, insn} pairs for the prefetch queue, with a
// synchronous flush that empties it in a single cycle.
module fetch_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_push,
   input  logic [ADDR_W-1:0]         i_pushPc,
   input  logic [INSN_W-1:0]         i_pushInsn,
   input  logic                      i_pop,
   input  logic                      i_flush,
   output logic                      o_valid,
   output logic [ADDR_W-1:0]         o_headPc,
   output logic [INSN_W-1:0]         o_headInsn,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_pcMem   [DEPTH];
   logic [INSN_W-1:0] r_insnMem [DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;

   logic w_doPush;
   logic w_doPop;

   // Flush wins over everything; full/empty guards keep the pointers consistent.
   assign w_doPush = i_push && !i_flush && (r_count != FULL_COUNT);
   assign w_doPop  = i_pop  && !i_flush && (r_count != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; entries are only read while counted as valid.
   always_ff @(posedge clock) begin
      if (w_doPush) begin
         r_pcMem[r_wrPtr]   <= i_pushPc;
         r_insnMem[r_wrPtr] <= i_pushInsn;
      end
   end

   assign o_valid    = (r_count != '0);
   assign o_headPc   = r_pcMem[r_rdPtr];
   assign o_headInsn = r_insnMem[r_rdPtr];
   assign o_count    = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: a single-outstanding-request fetch FSM that fills
// a small FIFO of {pc, insn} pairs and restarts cleanly on branch redirects.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INSN_W-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INSN_W-1:0] out_ir
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t      r_state;
   fetch_state_t      w_nextState;
   logic [ADDR_W-1:0] r_fetchPc;
   logic [ADDR_W-1:0] w_nextFetchPc;
   logic [ADDR_W-1:0] r_imemAddr;
   logic [ADDR_W-1:0] w_nextImemAddr;
   logic              r_imemReq;

   logic              w_push;
   logic              w_pop;
   logic              w_outValid;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_countNext;
   logic              w_hasCredit;
   logic [ADDR_W-1:0] w_redirectPc;
   logic [ADDR_W-1:0] w_seqPc;
   logic [ADDR_W-1:0] w_discardPc;

   // A redirect suppresses both the push of returning data and the pop of the head.
   assign w_push       = (r_state == REQ) && imem_ack && !redirect_valid;
   assign w_pop        = w_outValid && out_ready && !redirect_valid;
   assign w_countNext  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_hasCredit  = (w_countNext < CNT_W'(DEPTH));
   assign w_redirectPc = alignPc(redirect_pc);
   assign w_seqPc      = r_imemAddr + ADDR_W'(4);
   assign w_discardPc  = redirect_valid ? w_redirectPc : r_fetchPc;

   // Next-state logic: a new request only issues when the queue is guaranteed a
   // free slot once the data returns, so the FIFO can never overflow.
   always_comb begin
      w_nextState    = r_state;
      w_nextFetchPc  = r_fetchPc;
      w_nextImemAddr = r_imemAddr;
      case (r_state)
         IDLE: begin
            if (redirect_valid) begin
               w_nextFetchPc = w_redirectPc;
            end else if (w_hasCredit) begin
               w_nextState    = REQ;
               w_nextImemAddr = r_fetchPc;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               w_nextFetchPc = w_redirectPc;
               if (imem_ack) begin
                  w_nextImemAddr = w_redirectPc;
               end else begin
                  w_nextState = DISCARD;
               end
            end else if (imem_ack) begin
               w_nextFetchPc = w_seqPc;
               if (w_hasCredit) begin
                  w_nextImemAddr = w_seqPc;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         DISCARD: begin
            w_nextFetchPc = w_discardPc;
            if (imem_ack) begin
               w_nextState    = REQ;
               w_nextImemAddr = w_discardPc;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The request strobe is registered alongside the state so it never glitches.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_fetchPc  <= RESET_PC;
         r_imemAddr <= RESET_PC;
         r_imemReq  <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_fetchPc  <= w_nextFetchPc;
         r_imemAddr <= w_nextImemAddr;
         r_imemReq  <= (w_nextState != IDLE);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_push),
      .i_pushPc   (r_imemAddr),
      .i_pushInsn (imem_rdata),
      .i_pop      (w_pop),
      .i_flush    (redirect_valid),
      .o_valid    (w_outValid),
      .o_headPc   (out_pc),
      .o_headInsn (out_ir),
      .o_count    (w_count)
   );

   assign imem_req  = r_imemReq;
   assign imem_addr = r_imemAddr;
   assign out_valid = w_outValid;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of prefetch queue entries; legal values are powers of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0, is the first fetch address after reset.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 redirect_valid  in  1  branch or jump taken; flush the queue and restart fetch.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 imem_req  out  1  instruction memory read request (registered).
REQ-008 imem_addr  out  32  word-aligned read address; held stable while imem_req=1 and imem_ack=0.
REQ-009 imem_ack  in  1  read complete; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 out_valid  out  1  queue head holds a valid instruction.
REQ-012 out_ready  in  1  downstream CPU consumes the head; a pop occurs when out_valid=1 and out_ready=1.
REQ-013 out_pc  out  32  address of the head instruction (feeds the CPU's PC).
REQ-014 out_ir  out  32  head instruction word (feeds the CPU's IR).

Function
REQ-015 The block shall have one outstanding request at most; FSM states are IDLE (no request), REQ (imem_req=1, awaiting ack) and DISCARD (imem_req=1; the response will be dropped).
REQ-016 IDLE->REQ at an edge where no redirect is present and count_next<DEPTH; imem_addr=fetch_pc.
REQ-017 In REQ, on imem_ack: push {imem_addr, imem_rdata}, set fetch_pc=imem_addr+4 modulo 2^32 (0xFFFFFFFC wraps to 0), then stay in REQ if count_next<DEPTH, else go to IDLE.
REQ-018 With zero-wait memory (ack in the same cycle as req) and out_ready=1, the block shall sustain one instruction per cycle.
REQ-019 A pushed entry shall appear at the head with out_valid=1 in the cycle after the ack edge (1-cycle latency when the queue is empty).
REQ-020 count_next = count + push - pop; simultaneous push and pop shall leave count unchanged.
REQ-021 The queue shall never overflow (guaranteed by the REQ-016/017 credit check), and pop on empty shall be impossible.
REQ-022 On redirect_valid: empty the queue, set fetch_pc={redirect_pc[31:2],2'b00}, and set out_valid=0 from the next cycle.
REQ-023 Redirect in REQ without ack shall go to DISCARD with imem_req/imem_addr unchanged; the eventual ack data shall be dropped, then DISCARD->REQ with imem_addr=fetch_pc.
REQ-024 Redirect in the same cycle as imem_ack shall drop the ack data; the next state is REQ at the redirect address.
REQ-025 Redirect in the same cycle as a pop shall take priority; the pop is ignored and the queue is empty afterwards.
REQ-026 A redirect received while in DISCARD shall update fetch_pc only; the newest redirect wins.
REQ-027 out_pc/out_ir shall be driven from the queue head and are don't-care while out_valid=0.

Reset
REQ-028 While reset=1 (asynchronous): state=IDLE, fetch_pc=RESET_PC, count=0, queue pointers=0, imem_req=0, out_valid=0, and imem_addr=RESET_PC.
REQ-029 Reset asserted mid-request shall abandon the request; any ack arriving after reset is released while in IDLE shall be ignored.

Structure
REQ-030 A shared package shall hold the fetch-state enum (IDLE/REQ/DISCARD), INSN_W=32, ADDR_W=32 and the default RESET_PC.
REQ-031 The queue shall be a sub-module fetch_fifo (synchronous, DEPTH entries of {pc,insn}, push/pop/flush, count output); the FSM and fetch_pc reside in ifetch_queue.

Verification
REQ-032 Reset release, zero-wait memory returning word 0x8c080000 at address 0, out_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; out_pc=0 and out_ir=8c080000 one cycle after the first ack.
REQ-033 out_ready=0, DEPTH=4, zero-wait memory -> exactly 4 acks, then imem_req=0 with count=4; one pop -> one new request, imem_addr=16.
REQ-034 Ack delay of 3 cycles, redirect_pc=0x18 in the second wait cycle -> imem_addr remains at its old value until ack, that data is dropped, next request imem_addr=0x18, first out_pc=0x18.
REQ-035 redirect_pc=0x1B in the same cycle as ack and pop with 2 entries queued -> queue empty, next imem_addr=0x18, out_valid=0 for at least 1 cycle.
REQ-036 Redirect to 0xFFFFFFFC with zero-wait memory -> out_pc sequence FFFFFFFC, 00000000, 00000004.
REQ-037 Reset pulse between clock edges while in REQ -> imem_req=0 and out_valid=0 immediately; after release, fetch restarts at RESET_PC.
